// File: rtl/rs_issue_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_issue_reg_pkg
// Description : Shared types and constants for the RS issue pipeline
//               register. This package defines the function-unit encoding,
//               the default RS geometry and the packed issue-packet layout.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_issue_reg_pkg;

    // Function-unit class carried alongside every issued packet
    typedef enum logic [1:0] {
        ALU  = 2'd0,
        MULT = 2'd1,
        LS   = 2'd2,
        BR   = 2'd3
    } FUNC_UNIT;

    localparam int RS_SIZE     = 16;
    localparam int ISSUE_PKT_W = 64;
    localparam int RS_IDX_W    = $clog2(RS_SIZE);

    // Layout of one issued lane as seen by a function unit
    typedef struct packed {
        logic                   valid;
        FUNC_UNIT               func;
        logic [RS_IDX_W-1:0]    idx;
        logic [ISSUE_PKT_W-1:0] pkt;
    } ISSUE_PKT;

endpackage
`default_nettype wire

// File: rtl/rs_issue_reg_onehot_mux_enc.sv
`default_nettype none
// ============================================================================
// Module      : onehot_mux_enc
// Description : AND-OR multiplexer driven by a one-hot (or zero) select.
//               It also produces the binary index of the selected slot.
//               When the select is zero, both outputs are zero.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_mux_enc #(
    parameter int WIDTH = 16,
    parameter int PKT_W = 64,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]            sel_i,
    input  logic [WIDTH-1:0][PKT_W-1:0] data_i,
    output logic [PKT_W-1:0]            data_o,
    output logic [IDX_W-1:0]            idx_o
);

    // OR together every slot whose select bit is set; one-hot makes this a mux
    always_comb begin
        data_o = '0;
        idx_o  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel_i[i]) begin
                data_o = data_o | data_i[i];
                idx_o  = idx_o  | IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rs_issue_reg.sv
`default_nettype none
// ============================================================================
// Module      : rs_issue_reg
// Description : Issue pipeline register between the two-stage RS select and
//               the execute-stage function units. Lane 0 carries the stage-1
//               ALU grant. Lane 1 carries the stage-2 non-ALU grant. Each lane
//               has a valid/ready handshake toward its FU. rs_free reports
//               which slots were actually accepted this cycle.
//               Optional macro RS_ISSUE_PERF_EN adds per-lane transfer and
//               stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_issue_reg
    import rs_issue_reg_pkg::*;
#(
    parameter int WIDTH = RS_SIZE,
    parameter int PKT_W = ISSUE_PKT_W,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        squash,
    input  logic [WIDTH-1:0]            gnt0,
    input  logic [WIDTH-1:0]            gnt1,
    input  FUNC_UNIT                    func1,
    input  logic [WIDTH-1:0][PKT_W-1:0] rs_pkt,
    input  logic [1:0]                  fu_ready,
    output logic [1:0]                  iss_valid,
    output logic [1:0][PKT_W-1:0]       iss_pkt,
    output logic [1:0][IDX_W-1:0]       iss_idx,
    output logic [1:0][1:0]             iss_func,
    output logic [WIDTH-1:0]            rs_free,
    output logic [1:0]                  sel_stall
`ifdef RS_ISSUE_PERF_EN
    ,
    output logic [1:0][31:0]            perf_issue_cnt,
    output logic [1:0][31:0]            perf_stall_cnt
`endif
);

    // Lane-1 grant with any slot already claimed by lane 0 removed
    logic [WIDTH-1:0]            g1m;
    logic [1:0][WIDTH-1:0]       lane_gnt;
    logic [1:0]                  lane_any;
    logic [1:0]                  lane_open;
    logic [1:0]                  lane_acc;

    logic [1:0][PKT_W-1:0]       mux_pkt;
    logic [1:0][IDX_W-1:0]       mux_idx;

    logic [1:0]                  valid_q,  valid_d;
    logic [1:0][PKT_W-1:0]       pkt_q,    pkt_d;
    logic [1:0][IDX_W-1:0]       idx_q,    idx_d;
    FUNC_UNIT                    func1_q,  func1_d;

    assign g1m      = gnt1 & ~gnt0;
    assign lane_gnt = {g1m, gnt0};
    assign lane_any = {|g1m, |gnt0};

    // A lane can take a new packet when it is empty or its FU is taking the current one
    assign lane_open = ~valid_q | fu_ready;
    assign lane_acc  = lane_open & lane_any & {2{~squash}};

    assign rs_free   = ({WIDTH{lane_acc[0]}} & gnt0) | ({WIDTH{lane_acc[1]}} & g1m);
    assign sel_stall = lane_any & ~lane_open & {2{~squash}};

    generate
        for (genvar k = 0; k < 2; k++) begin : g_lane
            onehot_mux_enc #(
                .WIDTH (WIDTH),
                .PKT_W (PKT_W),
                .IDX_W (IDX_W)
            ) u_mux (
                .sel_i  (lane_gnt[k]),
                .data_i (rs_pkt),
                .data_o (mux_pkt[k]),
                .idx_o  (mux_idx[k])
            );
        end
    endgenerate

    // Per-lane next state: squash empties the lane, an open lane reloads, a blocked lane holds
    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        idx_d   = idx_q;
        func1_d = func1_q;
        for (int k = 0; k < 2; k++) begin
            if (squash) begin
                valid_d[k] = 1'b0;
            end else if (lane_open[k]) begin
                valid_d[k] = lane_any[k];
            end
            if (lane_acc[k]) begin
                pkt_d[k] = mux_pkt[k];
                idx_d[k] = mux_idx[k];
            end
        end
        if (lane_acc[1]) begin
            func1_d = func1;
        end
    end

    // Issue register; the reset drops any in-flight packet
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            pkt_q   <= '0;
            idx_q   <= '0;
            func1_q <= ALU;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
            idx_q   <= idx_d;
            func1_q <= func1_d;
        end
    end

    assign iss_valid   = valid_q;
    assign iss_pkt     = pkt_q;
    assign iss_idx     = idx_q;
    assign iss_func[0] = ALU;
    assign iss_func[1] = func1_q;

`ifdef RS_ISSUE_PERF_EN
    logic [1:0][31:0] perf_issue_q;
    logic [1:0][31:0] perf_stall_q;

    // Count FU transfers and select stalls per lane; the counters wrap and ignore squash
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                perf_issue_q[k] <= perf_issue_q[k] + 32'(valid_q[k] & fu_ready[k]);
                perf_stall_q[k] <= perf_stall_q[k] + 32'(sel_stall[k]);
            end
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

`ifndef SYNTHESIS
    // Grant sanity: each grant must be one-hot or zero. An overlapping lane-1 grant is dropped.
    always @(posedge clock) begin
        if (reset_n) begin
            assert ($onehot0(gnt0)) else $error("gnt0 is not one-hot: %h", gnt0);
            assert ($onehot0(gnt1)) else $error("gnt1 is not one-hot: %h", gnt1);
            assert ((gnt0 & gnt1) == '0)
                else $warning("gnt1 overlaps gnt0 (%h); lane-1 grant dropped", gnt0 & gnt1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_issue_reg
// Description : Directed self-checking bench for rs_issue_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_issue_reg;
    import rs_issue_reg_pkg::*;

    localparam int C_WIDTH = 16;
    localparam int C_PKT_W = 64;
    localparam int C_IDX_W = 4;

    logic                            clock;
    logic                            reset_n;
    logic                            squash;
    logic [C_WIDTH-1:0]              gnt0;
    logic [C_WIDTH-1:0]              gnt1;
    FUNC_UNIT                        func1;
    logic [C_WIDTH-1:0][C_PKT_W-1:0] rs_pkt;
    logic [1:0]                      fu_ready;
    logic [1:0]                      iss_valid;
    logic [1:0][C_PKT_W-1:0]         iss_pkt;
    logic [1:0][C_IDX_W-1:0]         iss_idx;
    logic [1:0][1:0]                 iss_func;
    logic [C_WIDTH-1:0]              rs_free;
    logic [1:0]                      sel_stall;
`ifdef RS_ISSUE_PERF_EN
    logic [1:0][31:0]                perf_issue_cnt;
    logic [1:0][31:0]                perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    rs_issue_reg #(
        .WIDTH (C_WIDTH),
        .PKT_W (C_PKT_W),
        .IDX_W (C_IDX_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .squash    (squash),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .func1     (func1),
        .rs_pkt    (rs_pkt),
        .fu_ready  (fu_ready),
        .iss_valid (iss_valid),
        .iss_pkt   (iss_pkt),
        .iss_idx   (iss_idx),
        .iss_func  (iss_func),
        .rs_free   (rs_free),
        .sel_stall (sel_stall)
`ifdef RS_ISSUE_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Fixed, distinct payload for each RS slot
    function automatic logic [63:0] slot_pkt(input int i);
        return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0000_0101_0101_0101);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        squash   = 1'b0;
        gnt0     = '0;
        gnt1     = '0;
        func1    = ALU;
        fu_ready = 2'b11;
        for (int i = 0; i < C_WIDTH; i++) rs_pkt[i] = slot_pkt(i);

        // Reset state
        #2;
        check_eq("rst_valid",  64'(iss_valid),   64'h0);
        check_eq("rst_pkt0",   iss_pkt[0],       64'h0);
        check_eq("rst_idx1",   64'(iss_idx[1]),  64'h0);
        check_eq("rst_func1",  64'(iss_func[1]), 64'(ALU));
        check_eq("rst_free",   64'(rs_free),     64'h0);
        check_eq("rst_stall",  64'(sel_stall),   64'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Lane 0 single grant: same-cycle free, one-cycle issue latency
        gnt0 = 16'h0004;
        #1;
        check_eq("t1_free", 64'(rs_free), 64'h0004);
        tick();
        gnt0 = '0;
        check_eq("t1_valid", 64'(iss_valid),   64'b01);
        check_eq("t1_idx0",  64'(iss_idx[0]),  64'd2);
        check_eq("t1_pkt0",  iss_pkt[0],       slot_pkt(2));
        check_eq("t1_func0", 64'(iss_func[0]), 64'(ALU));

        // Lane 1 loaded, then blocked while a new grant waits
        fu_ready = 2'b01;
        gnt1     = 16'h0020;
        func1    = LS;
        tick();
        check_eq("t2_load_idx1", 64'(iss_idx[1]), 64'd5);
        gnt1  = 16'h0100;
        func1 = MULT;
        #1;
        check_eq("t2_stall", 64'(sel_stall), 64'b10);
        check_eq("t2_free",  64'(rs_free),   64'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("t2_hold_valid", 64'(iss_valid[1]), 64'h1);
            check_eq("t2_hold_idx1",  64'(iss_idx[1]),   64'd5);
            check_eq("t2_hold_pkt1",  iss_pkt[1],        slot_pkt(5));
            check_eq("t2_hold_func1", 64'(iss_func[1]),  64'(LS));
            check_eq("t2_hold_stall", 64'(sel_stall),    64'b10);
        end
        fu_ready = 2'b11;
        #1;
        check_eq("t2_rel_free",  64'(rs_free),   64'h0100);
        check_eq("t2_rel_stall", 64'(sel_stall), 64'b00);
        tick();
        gnt1 = '0;
        check_eq("t2_new_valid", 64'(iss_valid),   64'b10);
        check_eq("t2_new_idx1",  64'(iss_idx[1]),  64'd8);
        check_eq("t2_new_pkt1",  iss_pkt[1],       slot_pkt(8));
        check_eq("t2_new_func1", 64'(iss_func[1]), 64'(MULT));
        tick();
        check_eq("t2_drain", 64'(iss_valid), 64'b00);

        // Streaming on lane 0: a new slot every cycle with no bubble
        for (int i = 0; i < C_WIDTH; i++) begin
            gnt0 = 16'(1 << i);
            #1;
            check_eq("t3_free", 64'(rs_free), 64'(1 << i));
            tick();
            check_eq("t3_valid", 64'(iss_valid[0]), 64'h1);
            check_eq("t3_idx0",  64'(iss_idx[0]),   64'(i));
        end
        check_eq("t3_last_pkt", iss_pkt[0], slot_pkt(15));
        gnt0 = '0;

        // Squash with both lanes valid, FUs stalled, and a fresh grant
        gnt0  = 16'h0001;
        gnt1  = 16'h0002;
        func1 = BR;
        tick();
        check_eq("t4_both_valid", 64'(iss_valid), 64'b11);
        gnt1     = '0;
        fu_ready = 2'b00;
        squash   = 1'b1;
        #1;
        check_eq("t4_free",  64'(rs_free),   64'h0);
        check_eq("t4_stall", 64'(sel_stall), 64'b00);
        tick();
        squash   = 1'b0;
        gnt0     = '0;
        fu_ready = 2'b11;
        check_eq("t4_valid", 64'(iss_valid), 64'b00);

        // Overlapping grants: only lane 0 takes the slot
        gnt0  = 16'h0010;
        gnt1  = 16'h0010;
        func1 = MULT;
        #1;
        check_eq("t5_free", 64'(rs_free), 64'h0010);
        tick();
        gnt0 = '0;
        gnt1 = '0;
        check_eq("t5_valid", 64'(iss_valid),  64'b01);
        check_eq("t5_idx0",  64'(iss_idx[0]), 64'd4);

        // Async reset while lane 0 is stalled
        fu_ready = 2'b10;
        gnt0     = 16'h0008;
        #1;
        check_eq("t6_stall", 64'(sel_stall), 64'b01);
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", 64'(iss_valid),  64'b00);
        check_eq("t6_rst_idx0",  64'(iss_idx[0]), 64'h0);
        gnt0 = '0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
`ifdef RS_ISSUE_PERF_EN
        check_eq("t6_perf_issue", 64'(perf_issue_cnt), 64'h0);
        check_eq("t6_perf_stall", 64'(perf_stall_cnt), 64'h0);
`endif
        tick();
        check_eq("t6_post_valid", 64'(iss_valid), 64'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
